// File: rtl/ahbgpio_param.sv
// AHB-Lite GPIO slave: WIDTH-bit data/direction registers, synchronised inputs,
// selectable-sense parity check and masked rising-edge interrupts with W1C status.
module ahbgpio_param #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  input  logic             PARITYSEL,
  output logic [WIDTH-1:0] GPIOOUT,
  output logic [WIDTH-1:0] GPIOOE,
  output logic             PARITYERR,
  output logic             IRQ
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_IN     = 3'd2,
    REG_MASK   = 3'd3,
    REG_STATUS = 3'd4
  } reg_sel_e;

  logic             valid_q, valid_d;
  logic             write_q, write_d;
  reg_sel_e         addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH:0]   mask_q, mask_d;
  logic [WIDTH:0]   status_q, status_d;
  logic [WIDTH:0]   sync_q [SYNC_STAGES];
  logic [WIDTH:0]   sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             perr_q, perr_d;
  logic             irq_q, irq_d;

  logic [WIDTH:0]   sync;
  logic             wr_en;
  logic [WIDTH:0]   set_bits;
  logic [WIDTH:0]   clr_bits;
  logic             unused_ok;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  always_comb begin
    valid_d = HSEL & HTRANS[1] & HREADY;
    addr_d  = reg_sel_e'(HADDR[4:2]);
    write_d = HWRITE;
    wr_en   = valid_q & write_q;

    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr_en) begin
      case (addr_q)
        REG_DATA: data_d = HWDATA[WIDTH-1:0];
        REG_DIR:  dir_d  = HWDATA[WIDTH-1:0];
        REG_MASK: mask_d = HWDATA[WIDTH:0];
        default:  ;
      endcase
    end

    // Parity flag uses the registered error so it lines up with PARITYERR.
    set_bits = {perr_q, sync[WIDTH-1:0] & ~prev_q};
    clr_bits = (wr_en && addr_q == REG_STATUS) ? HWDATA[WIDTH:0] : '0;
    status_d = (status_q & ~clr_bits) | set_bits;

    prev_d = sync[WIDTH-1:0];
    perr_d = (^sync) != PARITYSEL;
    irq_d  = |(status_q & mask_q);

    sync_d[0] = GPIOIN;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= REG_DATA;
      data_q   <= '0;
      dir_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      perr_q   <= 1'b0;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      prev_q   <= prev_d;
      perr_q   <= perr_d;
      irq_q    <= irq_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q) begin
      case (addr_q)
        REG_DATA:   HRDATA[WIDTH-1:0] = data_q;
        REG_DIR:    HRDATA[WIDTH-1:0] = dir_q;
        REG_IN:     HRDATA[WIDTH-1:0] = sync[WIDTH-1:0];
        REG_MASK:   HRDATA[WIDTH:0]   = mask_q;
        REG_STATUS: HRDATA[WIDTH:0]   = status_q;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = data_q & dir_q;
  assign GPIOOE    = dir_q;
  assign PARITYERR = perr_q;
  assign IRQ       = irq_q;

endmodule

// File: doc/ahbgpio_param.md
Name: ahbgpio_param

Overview:
Parametrised successor to the AHB-Lite GPIO peripheral. Provides WIDTH-bit GPIO with a per-bit direction register, synchronised inputs, and parity checking with selectable odd/even sense. Adds rising-edge interrupt detection with per-bit mask and write-1-to-clear status. Sits on the AHB-Lite bus as a zero-wait-state slave behind the address decoder/mux, alongside the other AHB peripherals.

Parameters:
WIDTH, 16, GPIO data width in bits; legal range 1..31 (status bit WIDTH holds the parity flag)
SYNC_STAGES, 2, input synchroniser depth; legal range 2..3

Ports:
HCLK  in  1  system clock; all logic on rising edge
HRESET  in  1  reset, synchronous, active-high
HSEL  in  1  slave select
HADDR  in  32  byte address; only HADDR[4:2] decoded
HTRANS  in  2  transfer type; bit1=1 (NONSEQ/SEQ) marks a valid transfer
HWRITE  in  1  1 = write
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus ready
HREADYOUT  out  1  constant 1 (no wait states)
HRDATA  out  32  read data, valid in the data phase
GPIOIN  in  WIDTH+1  [WIDTH-1:0] pin data, [WIDTH] parity bit
PARITYSEL  in  1  0 = even parity, 1 = odd parity
GPIOOUT  out  WIDTH  DATA & DIR
GPIOOE  out  WIDTH  output enables (= DIR)
PARITYERR  out  1  registered parity mismatch on the current synchronised sample
IRQ  out  1  |(STATUS & MASK)

Behaviour:
- Interface: one clock (HCLK); reset (HRESET) is synchronous and active-high.
- Register map (HADDR[4:2]): 0 DATA rw, 1 DIR rw, 2 IN ro (synchronised pins), 3 MASK rw (WIDTH+1 bits), 4 STATUS r/W1C (WIDTH+1 bits), 5-7 unmapped.
- Address phase: when HSEL & HTRANS[1] & HREADY, register HADDR[4:2], HWRITE and valid=1; otherwise valid=0.
- Data phase write: at the following rising edge, update the target register from HWDATA[WIDTH-1:0] (MASK and STATUS use [WIDTH:0]). Upper bits are ignored.
- Data phase read: HRDATA is combinational from the registered address, zero-extended. When valid=0, or on IN/unmapped reads, return 0 for unmapped only; IN returns the synchronised value.
- Back-to-back write then read of the same register returns the new value.
- Writes to IN or to unmapped addresses are ignored.
- Input path: GPIOIN passes through a SYNC_STAGES flop chain to give `sync`. A read of IN sees a pin change SYNC_STAGES cycles later. `prev` holds `sync` delayed by 1 cycle.
- Parity: `perr` = (^sync[WIDTH:0]) != PARITYSEL, i.e. the total count of ones must be even when PARITYSEL=0 and odd when PARITYSEL=1. PARITYERR is registered `perr`, so it lags `sync` by 1 cycle.
- STATUS[i] for i<WIDTH is set when sync[i] & ~prev[i]. STATUS[WIDTH] is set on a registered perr=1. The set condition is sticky until software clears it.
- W1C: a write of 1 to a STATUS bit clears it. If set and clear occur in the same cycle, set wins.
- IRQ is registered: |(STATUS & MASK) from the previous edge.
- Reset values: DATA, DIR, MASK, STATUS = 0; sync chain and prev = 0; valid = 0; GPIOOUT = 0; GPIOOE = 0; PARITYERR = 0; IRQ = 0; HRDATA = 0; HREADYOUT = 1.
- Reset mid-transfer: the pending data-phase write is dropped (valid cleared), and no edge or parity event is recorded in the cycle reset is high.
- The first cycle after reset cannot generate a spurious edge, because prev and sync both start at 0.

Test Plan:
- Reset: hold HRESET for 5 cycles. Read every register -> all read 0. GPIOOUT=0, IRQ=0, PARITYERR=0, HREADYOUT=1.
- Output enable: write DIR=0x00FF, then DATA=0xA5A5 -> GPIOOUT=0x00A5, GPIOOE=0x00FF. Read DATA -> 0xA5A5 (back-to-back read gives the new value).
- Input latency and parity: with PARITYSEL=0, drive GPIOIN data=0x0003, parity=0 -> IN reads 0x0003 after 2 cycles, PARITYERR=0. Change parity to 1 -> PARITYERR=1 three cycles later, and STATUS[16]=1.
- Edge IRQ: MASK=0x0001. Drive GPIOIN[0] 0->1 -> STATUS[0]=1, then IRQ=1 one cycle after the status bit sets. A falling edge sets nothing.
- W1C collision: write STATUS=0x0001 in the same cycle as a new rising edge on bit 0 -> STATUS[0] stays 1. A later write of 0x0001 with no edge clears it and IRQ drops.
- Mid-transfer reset: assert HRESET during the data phase of a DATA write of 0xFFFF -> DATA=0, GPIOOUT=0 after reset. Repeat at WIDTH=8 and WIDTH=31 -> upper write bits are ignored and the parity flag sits at bit WIDTH.
